// File: rtl/dcache_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dcache_req_arbiter_pkg
// Shared types and constants for the dcache request arbiter: FSM state type,
// default requester count / sid base, and the fixed requester indices.
// -----------------------------------------------------------------------------
package dcache_req_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DCACHE_ARB_N_REQ    = 3;
    localparam int DCACHE_ARB_SID_BASE = 1;

    localparam int REQ_LSU = 0;
    localparam int REQ_PTW = 1;
    localparam int REQ_PF  = 2;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_pkg.sv
// -----------------------------------------------------------------------------
// hpdcache_pkg
// Request/response payload types of the HPDC core request port, shared by the
// core-side requesters and the data cache. Only the fields the arbiter and its
// neighbours need are modelled here.
// -----------------------------------------------------------------------------
package hpdcache_pkg;

    localparam int HPDCACHE_SID_W = 4;

    typedef logic [HPDCACHE_SID_W-1:0] hpdcache_sid_t;

    typedef struct packed {
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic [3:0]    op;
        hpdcache_sid_t sid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]   rdata;
        logic          error;
        hpdcache_sid_t sid;
    } hpdcache_rsp_t;

endpackage

// File: rtl/dcache_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// dcache_req_arbiter_if
// Bundles the request/response handshakes around the arbiter:
//   requester side : req_valid_i, req_i, req_ready_o, rsp_valid_o, rsp_o
//   HPDC side      : dcache_req_valid_o, dcache_req_o, dcache_req_ready_i,
//                    dcache_rsp_valid_i, dcache_rsp_i
// Suffixes give the direction as seen by the arbiter.
// Modports: slave = the arbiter, master = its environment.
// -----------------------------------------------------------------------------
interface dcache_req_arbiter_if #(
    parameter int N_REQ = 3
);

    logic [N_REQ-1:0]                         req_valid_i;
    hpdcache_pkg::hpdcache_req_t [N_REQ-1:0]  req_i;
    logic [N_REQ-1:0]                         req_ready_o;
    logic [N_REQ-1:0]                         rsp_valid_o;
    hpdcache_pkg::hpdcache_rsp_t              rsp_o;

    logic                                     dcache_req_valid_o;
    hpdcache_pkg::hpdcache_req_t              dcache_req_o;
    logic                                     dcache_req_ready_i;
    logic                                     dcache_rsp_valid_i;
    hpdcache_pkg::hpdcache_rsp_t              dcache_rsp_i;

    modport slave (
        input  req_valid_i, req_i, dcache_req_ready_i, dcache_rsp_valid_i, dcache_rsp_i,
        output req_ready_o, rsp_valid_o, rsp_o, dcache_req_valid_o, dcache_req_o
    );

    modport master (
        output req_valid_i, req_i, dcache_req_ready_i, dcache_rsp_valid_i, dcache_rsp_i,
        input  req_ready_o, rsp_valid_o, rsp_o, dcache_req_valid_o, dcache_req_o
    );

endinterface

// File: rtl/dcache_req_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// dcache_req_arbiter_rr_pick
// Combinational round-robin picker: returns the first set bit of elig_i at or
// after ptr_i, wrapping around.
//   elig_i : eligible mask
//   ptr_i  : highest-priority index this cycle
//   win_o  : selected index (0 when any_o=0)
//   any_o  : at least one eligible requester
// -----------------------------------------------------------------------------
module dcache_req_arbiter_rr_pick
    import dcache_req_arbiter_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int IW    = arb_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    win_o,
    output logic             any_o
);

    // Walk from the farthest offset back to the pointer so the closest
    // eligible index is the last one written.
    always_comb begin
        int idx;
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (elig_i[idx]) begin
                win_o = IW'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_req_arbiter
// Shares the single HPDC request port between N_REQ requesters (0 = LSU,
// 1 = page-table walker, 2 = prefetcher). Round-robin pick with the grant held
// until the HPDC accepts it, per-requester outstanding limit, response routing
// by sid, and a drain hook for fences / satp / sfence flushes.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   bus            request/response handshakes (dcache_req_arbiter_if.slave)
//   drain_i        block new grants
//   drain_done_o   draining and nothing in flight
//   err_o          sticky protocol error (bad sid, response with nothing owed)
//   stall_cnt_o    per-requester stall cycle counters, only when
//                  DCACHE_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module dcache_req_arbiter
    import hpdcache_pkg::*;
    import dcache_req_arbiter_pkg::*;
#(
    parameter int N_REQ           = DCACHE_ARB_N_REQ,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SID_BASE        = DCACHE_ARB_SID_BASE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    dcache_req_arbiter_if.slave    bus,
    input  logic                   drain_i,
    output logic                   drain_done_o,
    output logic                   err_o
`ifdef DCACHE_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0] stall_cnt_o
`endif
);

    localparam int IW = arb_idx_w(N_REQ);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t       state_q;
    logic [IW-1:0]    gnt_q;
    logic [IW-1:0]    rr_ptr_q;
    logic             err_q;
    logic [CW-1:0]    cnt_q [N_REQ];
    logic [CW-1:0]    cnt_d [N_REQ];

    logic [N_REQ-1:0] elig;
    logic [IW-1:0]    pick_win;
    logic             pick_any;
    logic [IW-1:0]    sel;
    logic             dc_valid;
    logic             hs;
    logic [N_REQ-1:0] rsp_hit;
    logic             rsp_err;
    logic             all_idle;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(N_REQ - 1)) ? '0 : p + IW'(1);
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req_valid_i[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
        end
    end

    dcache_req_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .elig_i (elig),
        .ptr_i  (rr_ptr_q),
        .win_o  (pick_win),
        .any_o  (pick_any)
    );

    // A locked grant ignores both the picker and drain_i: once the HPDC has
    // seen the request it must stay stable until accepted.
    assign sel      = (state_q == LOCKED) ? gnt_q : pick_win;
    assign dc_valid = !rst_i && ((state_q == LOCKED) || (!drain_i && pick_any));
    assign hs       = dc_valid && bus.dcache_req_ready_i;

    always_comb begin
        bus.dcache_req_valid_o = dc_valid;
        bus.dcache_req_o       = bus.req_i[sel];
        bus.dcache_req_o.sid   = hpdcache_sid_t'(SID_BASE + int'(sel));
        bus.req_ready_o        = '0;
        bus.req_ready_o[sel]   = hs;
    end

    // Response routing and error detection.
    always_comb begin
        logic in_range;
        in_range = 1'b0;
        rsp_err  = 1'b0;
        rsp_hit  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_hit[i] = !rst_i && bus.dcache_rsp_valid_i
                         && (int'(bus.dcache_rsp_i.sid) == SID_BASE + i);
            if (rsp_hit[i]) begin
                in_range = 1'b1;
                if (cnt_q[i] == '0) rsp_err = 1'b1;
            end
        end
        if (!rst_i && bus.dcache_rsp_valid_i && !in_range) rsp_err = 1'b1;
        bus.rsp_valid_o = rsp_hit;
        bus.rsp_o       = bus.dcache_rsp_i;
    end

    // A response to a requester with nothing owed is flagged and never
    // decrements, so the counter cannot underflow.
    always_comb begin
        logic inc;
        logic dec;
        all_idle = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            inc      = hs && (sel == IW'(i));
            dec      = rsp_hit[i] && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc && !dec)      cnt_d[i] = cnt_q[i] + CW'(1);
            else if (dec && !inc) cnt_d[i] = cnt_q[i] - CW'(1);
            if (cnt_d[i] != '0) all_idle = 1'b0;
        end
    end

    // Uses next-state counts so the last response already reports drained.
    assign drain_done_o = drain_i && (state_q == IDLE) && all_idle;
    assign err_o        = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_q | rsp_err;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        rr_ptr_q <= next_ptr(sel);
                    end else if (dc_valid) begin
                        state_q <= LOCKED;
                        gnt_q   <= sel;
                    end
                end
                LOCKED: begin
                    if (bus.dcache_req_ready_i) begin
                        rr_ptr_q <= next_ptr(gnt_q);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst_i) cnt_q[i] <= '0;
            else       cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef DCACHE_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst_i) begin
                stall_cnt_o[i] <= '0;
            end else if (bus.req_valid_i[i] && !bus.req_ready_o[i]) begin
                stall_cnt_o[i] <= stall_cnt_o[i] + 32'd1;
            end
        end
    end
`endif

endmodule
